// File: rtl/chacha_spi_pkg.sv
// Shared opcode, region-size and readback-state definitions for the ChaCha SPI
// parameter writer and readback transmitter.
package chacha_spi_pkg;

  localparam logic [7:0] WR_KEY   = 8'd1;
  localparam logic [7:0] WR_NONCE = 8'd2;
  localparam logic [7:0] WR_POS   = 8'd3;
  localparam logic [7:0] RD_KEY   = 8'd4;
  localparam logic [7:0] RD_NONCE = 8'd5;
  localparam logic [7:0] RD_POS   = 8'd6;
  localparam logic [7:0] START    = 8'd7;

  localparam logic [5:0] KEY_BYTES   = 6'd32;
  localparam logic [5:0] NONCE_BYTES = 6'd12;
  localparam logic [5:0] POS_BYTES   = 6'd4;

  typedef enum logic [1:0] {
    RB_IDLE,
    RB_SKIP,
    RB_SEND
  } rb_state_e;

  typedef enum logic [1:0] {
    RGN_KEY,
    RGN_NONCE,
    RGN_POS
  } rgn_e;

  function automatic logic [5:0] region_len(input rgn_e r);
    case (r)
      RGN_KEY:   return KEY_BYTES;
      RGN_NONCE: return NONCE_BYTES;
      default:   return POS_BYTES;
    endcase
  endfunction

endpackage

// File: rtl/readback_byte_sel.sv
// Combinational byte picker: returns byte idx of the snapshot for the given
// region, or zero once idx is past the end of that region.
module readback_byte_sel
  import chacha_spi_pkg::*;
(
  input  logic [255:0] snapshot,
  input  logic [1:0]   region,
  input  logic [5:0]   idx,
  output logic [7:0]   sel_byte
);

  always_comb begin
    sel_byte = '0;
    if (idx < region_len(rgn_e'(region))) begin
      sel_byte = snapshot[{idx[4:0], 3'b000} +: 8];
    end
  end

endmodule

// File: rtl/param_readback_tx.sv
// Readback transmitter: decodes read opcodes from the SPI RX stream and feeds
// snapshot bytes to the SPI TX register. Optional macro: READBACK_CHECKSUM_EN.
module param_readback_tx
  import chacha_spi_pkg::*;
#(
  parameter logic [7:0] IDLE_FILL = 8'h00
) (
  input  logic        i_Clk,
  input  logic        i_Rst_L,
  input  logic        o_RX_DV,
  input  logic [7:0]  o_RX_Byte,
  output logic        i_TX_DV,
  output logic [7:0]  i_TX_Byte,
  input  logic [31:0] io_key_0,
  input  logic [31:0] io_key_1,
  input  logic [31:0] io_key_2,
  input  logic [31:0] io_key_3,
  input  logic [31:0] io_key_4,
  input  logic [31:0] io_key_5,
  input  logic [31:0] io_key_6,
  input  logic [31:0] io_key_7,
  input  logic [31:0] io_nonce_0,
  input  logic [31:0] io_nonce_1,
  input  logic [31:0] io_nonce_2,
  input  logic [31:0] io_position,
  output logic        o_Busy
);

  rb_state_e    state_q, state_d;
  rgn_e         rgn_q, rgn_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [5:0]   idx_q, idx_d;
  logic [255:0] snap_q, snap_d;
  logic         tx_dv_q, tx_dv_d;
  logic [7:0]   tx_byte_q, tx_byte_d;
  logic         busy_q, busy_d;

  logic         ld_data, ld_csum, ld_fill;
  logic [7:0]   sel_byte, csum_byte;
  logic [5:0]   data_len, len_total;

  // The selector looks at the next-state snapshot so byte 0 is ready on the
  // same edge that captures the snapshot.
  readback_byte_sel u_byte_sel (
    .snapshot (snap_d),
    .region   (rgn_d),
    .idx      (idx_d),
    .sel_byte (sel_byte)
  );

`ifdef READBACK_CHECKSUM_EN
  localparam logic [5:0] CSUM_BYTES = 6'd1;
  logic [7:0] csum_q, csum_d;

  always_comb begin
    csum_d = csum_q;
    if (ld_data) begin
      csum_d = (state_q == RB_IDLE) ? sel_byte : (csum_q ^ sel_byte);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) csum_q <= '0;
    else          csum_q <= csum_d;
  end

  assign csum_byte = csum_q;
`else
  localparam logic [5:0] CSUM_BYTES = 6'd0;
  assign csum_byte = '0;
`endif

  assign data_len  = region_len(rgn_q);
  assign len_total = data_len + CSUM_BYTES;

  always_comb begin
    state_d = state_q;
    rgn_d   = rgn_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    ld_data = 1'b0;
    ld_csum = 1'b0;
    ld_fill = 1'b0;
    case (state_q)
      RB_IDLE: begin
        if (o_RX_DV) begin
          case (o_RX_Byte)
            WR_KEY:   begin state_d = RB_SKIP; cnt_d = KEY_BYTES;   end
            WR_NONCE: begin state_d = RB_SKIP; cnt_d = NONCE_BYTES; end
            WR_POS:   begin state_d = RB_SKIP; cnt_d = POS_BYTES;   end
            RD_KEY: begin
              rgn_d  = RGN_KEY;
              snap_d = {io_key_7, io_key_6, io_key_5, io_key_4,
                        io_key_3, io_key_2, io_key_1, io_key_0};
            end
            RD_NONCE: begin
              rgn_d  = RGN_NONCE;
              snap_d = {160'b0, io_nonce_2, io_nonce_1, io_nonce_0};
            end
            RD_POS: begin
              rgn_d  = RGN_POS;
              snap_d = {224'b0, io_position};
            end
            default: ;
          endcase
          if (o_RX_Byte inside {RD_KEY, RD_NONCE, RD_POS}) begin
            state_d = RB_SEND;
            idx_d   = '0;
            ld_data = 1'b1;
          end
        end
      end
      RB_SKIP: begin
        if (o_RX_DV) begin
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd1) state_d = RB_IDLE;
        end
      end
      RB_SEND: begin
        if (o_RX_DV) begin
          if (idx_q < len_total - 6'd1) begin
            idx_d = idx_q + 6'd1;
            if (idx_q + 6'd1 < data_len) ld_data = 1'b1;
            else                         ld_csum = 1'b1;
          end else begin
            ld_fill = 1'b1;
            idx_d   = '0;
            state_d = RB_IDLE;
          end
        end
      end
      default: state_d = RB_IDLE;
    endcase
  end

  always_comb begin
    tx_dv_d   = ld_data | ld_csum | ld_fill;
    tx_byte_d = tx_byte_q;
    if (ld_data)      tx_byte_d = sel_byte;
    else if (ld_csum) tx_byte_d = csum_byte;
    else if (ld_fill) tx_byte_d = IDLE_FILL;
    busy_d = (state_d != RB_IDLE);
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state_q   <= RB_IDLE;
      rgn_q     <= RGN_KEY;
      cnt_q     <= '0;
      idx_q     <= '0;
      snap_q    <= '0;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= IDLE_FILL;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rgn_q     <= rgn_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      tx_dv_q   <= tx_dv_d;
      tx_byte_q <= tx_byte_d;
      busy_q    <= busy_d;
    end
  end

  assign i_TX_DV   = tx_dv_q;
  assign i_TX_Byte = tx_byte_q;
  assign o_Busy    = busy_q;

endmodule

// File: tb/tb_param_readback_tx.sv
// Directed bench for param_readback_tx; honours READBACK_CHECKSUM_EN when defined.
module tb_param_readback_tx;

`ifdef READBACK_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        busy;
  logic [31:0] key_w [8];
  logic [31:0] nonce_w [3];
  logic [31:0] pos_w;

  int checks = 0;
  int errors = 0;
  logic [7:0] got [$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (tx_dv) got.push_back(tx_byte);
  end

  param_readback_tx #(.IDLE_FILL(8'h00)) dut (
    .i_Clk       (clk),
    .i_Rst_L     (rst_l),
    .o_RX_DV     (rx_dv),
    .o_RX_Byte   (rx_byte),
    .i_TX_DV     (tx_dv),
    .i_TX_Byte   (tx_byte),
    .io_key_0    (key_w[0]),
    .io_key_1    (key_w[1]),
    .io_key_2    (key_w[2]),
    .io_key_3    (key_w[3]),
    .io_key_4    (key_w[4]),
    .io_key_5    (key_w[5]),
    .io_key_6    (key_w[6]),
    .io_key_7    (key_w[7]),
    .io_nonce_0  (nonce_w[0]),
    .io_nonce_1  (nonce_w[1]),
    .io_nonce_2  (nonce_w[2]),
    .io_position (pos_w),
    .o_Busy      (busy)
  );

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_l = 1'b0;
    idle(3);
    checks++; if (tx_dv !== 1'b0) begin errors++; $display("FAIL reset_tx_dv got %b want 0", tx_dv); end
    checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL reset_tx_byte got %h want 00", tx_byte); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_l = 1'b1;
    idle(1);
  endtask

  task automatic test_key_readback;
    got.delete();
    send(8'h04);
    for (int i = 0; i < 32 + CS; i++) begin
      send(8'hA5);
      if (i == 30 + CS) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL key_busy_before_last got %b want 1", busy); end
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL key_busy_after_last got %b want 0", busy); end
    idle(2);
    checks++;
    if (got.size() !== 33 + CS) begin
      errors++; $display("FAIL key_pulse_count got %0d want %0d", got.size(), 33 + CS);
    end else begin
      for (int i = 0; i < 32; i++) begin
        checks++;
        if (got[i] !== 8'(i)) begin errors++; $display("FAIL key_byte[%0d] got %h want %h", i, got[i], 8'(i)); end
      end
      if (CS == 1) begin
        checks++; if (got[32] !== 8'h00) begin errors++; $display("FAIL key_checksum got %h want 00", got[32]); end
      end
      checks++; if (got[32 + CS] !== 8'h00) begin errors++; $display("FAIL key_fill got %h want 00", got[32 + CS]); end
    end
  endtask

  task automatic test_position_readback;
    logic [7:0] exp [$];
    exp = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    if (CS == 1) exp.push_back(8'h22);
    exp.push_back(8'h00);
    pos_w = 32'hDEADBEEF;
    got.delete();
    send(8'h06);
    for (int i = 0; i < 4 + CS; i++) send(8'h3C);
    idle(2);
    checks++;
    if (got.size() !== exp.size()) begin
      errors++; $display("FAIL pos_pulse_count got %0d want %0d", got.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        checks++;
        if (got[i] !== exp[i]) begin errors++; $display("FAIL pos_byte[%0d] got %h want %h", i, got[i], exp[i]); end
      end
    end
  endtask

  task automatic test_payload_skip;
    got.delete();
    send(8'h01);
    for (int i = 0; i < 32; i++) begin
      send(8'h04);
      if (i == 0) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL skip_busy got %b want 1", busy); end
      end
    end
    checks++; if (got.size() !== 0) begin errors++; $display("FAIL skip_tx_pulses got %0d want 0", got.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL skip_busy_end got %b want 0", busy); end
    send(8'h05);
    for (int i = 0; i < 12 + CS; i++) send(8'hFF);
    idle(2);
    checks++;
    if (got.size() !== 13 + CS) begin
      errors++; $display("FAIL nonce_pulse_count got %0d want %0d", got.size(), 13 + CS);
    end else begin
      for (int i = 0; i < 12; i++) begin
        checks++;
        if (got[i] !== 8'(16 + i)) begin errors++; $display("FAIL nonce_byte[%0d] got %h want %h", i, got[i], 8'(16 + i)); end
      end
      if (CS == 1) begin
        checks++; if (got[12] !== 8'h00) begin errors++; $display("FAIL nonce_checksum got %h want 00", got[12]); end
      end
      checks++; if (got[12 + CS] !== 8'h00) begin errors++; $display("FAIL nonce_fill got %h want 00", got[12 + CS]); end
    end
  endtask

  task automatic test_snapshot;
    logic [7:0] exp [$];
    exp = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    if (CS == 1) exp.push_back(8'h22);
    exp.push_back(8'h00);
    pos_w = 32'hDEADBEEF;
    got.delete();
    send(8'h06);
    send(8'h11);
    pos_w = 32'h0;
    for (int i = 0; i < 3 + CS; i++) send(8'h11);
    idle(2);
    checks++;
    if (got.size() !== exp.size()) begin
      errors++; $display("FAIL snap_pulse_count got %0d want %0d", got.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        checks++;
        if (got[i] !== exp[i]) begin errors++; $display("FAIL snap_byte[%0d] got %h want %h", i, got[i], exp[i]); end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp [$];
    exp = '{8'h78, 8'h56, 8'h34, 8'h12};
    if (CS == 1) exp.push_back(8'h08);
    exp.push_back(8'h00);
    pos_w = 32'h12345678;
    got.delete();
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = 8'h06;
    repeat (4 + CS) begin
      @(negedge clk);
      rx_byte = 8'hFF;
    end
    @(negedge clk);
    rx_dv = 1'b0;
    idle(2);
    checks++;
    if (got.size() !== exp.size()) begin
      errors++; $display("FAIL b2b_pulse_count got %0d want %0d", got.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        checks++;
        if (got[i] !== exp[i]) begin errors++; $display("FAIL b2b_byte[%0d] got %h want %h", i, got[i], exp[i]); end
      end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got %b want 0", busy); end
  endtask

  task automatic test_ignored;
    got.delete();
    send(8'h07);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy_07 got %b want 0", busy); end
    send(8'h00);
    send(8'h09);
    idle(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_busy got %b want 0", busy); end
    checks++; if (got.size() !== 0) begin errors++; $display("FAIL ign_tx_pulses got %0d want 0", got.size()); end
  endtask

  task automatic test_reset_mid_read;
    got.delete();
    send(8'h04);
    for (int i = 0; i < 10; i++) send(8'h5A);
    checks++; if (tx_byte !== 8'h0A) begin errors++; $display("FAIL mid_byte10 got %h want 0a", tx_byte); end
    rst_l = 1'b0;
    @(negedge clk);
    checks++; if (tx_dv !== 1'b0) begin errors++; $display("FAIL mid_rst_tx_dv got %b want 0", tx_dv); end
    checks++; if (tx_byte !== 8'h00) begin errors++; $display("FAIL mid_rst_tx_byte got %h want 00", tx_byte); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    rst_l = 1'b1;
    idle(2);
    checks++; if (got.size() !== 11) begin errors++; $display("FAIL mid_no_fill got %0d want 11", got.size()); end
    got.delete();
    send(8'h04);
    send(8'h5A);
    checks++;
    if (got.size() !== 2) begin
      errors++; $display("FAIL restart_count got %0d want 2", got.size());
    end else begin
      checks++; if (got[0] !== 8'h00) begin errors++; $display("FAIL restart_byte0 got %h want 00", got[0]); end
      checks++; if (got[1] !== 8'h01) begin errors++; $display("FAIL restart_byte1 got %h want 01", got[1]); end
    end
    for (int i = 0; i < 31 + CS; i++) send(8'h5A);
    idle(2);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL restart_busy_end got %b want 0", busy); end
  endtask

  initial begin
    for (int n = 0; n < 8; n++)
      key_w[n] = {8'(4*n + 3), 8'(4*n + 2), 8'(4*n + 1), 8'(4*n)};
    for (int n = 0; n < 3; n++)
      nonce_w[n] = {8'(16 + 4*n + 3), 8'(16 + 4*n + 2), 8'(16 + 4*n + 1), 8'(16 + 4*n)};
    pos_w = 32'h0;

    test_reset;
    test_key_readback;
    test_position_readback;
    test_payload_skip;
    test_snapshot;
    test_back_to_back;
    test_ignored;
    test_reset_mid_read;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_readback_tx.md
Name: param_readback_tx

Overview:
- Transmit-side companion to the SPI parameter writer.
- Decodes read opcodes 4/5/6 from the SPI slave RX stream, snapshots the key, nonce or position, and serializes the selected bytes into the SPI slave TX register, one byte per SPI transfer.
- Tracks write-command payloads (opcodes 1/2/3) so that payload bytes are never decoded as opcodes.
- Sits between the SPI slave and the ChaCha parameter registers, in parallel with the writer.

Parameters:
- IDLE_FILL, 8'h00: byte loaded into TX when idle and after a readback completes, so the slave never re-sends stale secret bytes.

Ports:
- i_Clk  in  1  clock
- i_Rst_L  in  1  reset; synchronous, active-low
- o_RX_DV  in  1  SPI slave byte-received pulse (1 cycle)
- o_RX_Byte  in  8  byte received on MOSI
- i_TX_DV  out  1  load pulse for the SPI slave TX register
- i_TX_Byte  out  8  byte to serialize on MISO
- io_key_0..io_key_7  in  32 each  current key words
- io_nonce_0..io_nonce_2  in  32 each  current nonce words
- io_position  in  32  current position word
- o_Busy  out  1  high while in SKIP or SEND

Behaviour:
- All outputs are registered.
- Reset values: i_TX_DV=0, i_TX_Byte=IDLE_FILL, o_Busy=0, state=IDLE, idx=0, snapshot=0.
- Byte order: byte n of a region is bits [8(n%4)+7 : 8(n%4)] of word n/4. Region lengths: key 32, nonce 12, position 4.
- States are IDLE, SKIP and SEND. o_RX_DV is acted on only in the cycle it is high.
- IDLE, o_RX_DV high:
  - Opcode 1/2/3: go to SKIP with remaining count = 32/12/4.
  - Opcode 4/5/6: capture the snapshot of the selected region, set idx=0 and go to SEND. Next cycle: i_TX_DV=1, i_TX_Byte=byte0. Latency from the command pulse is 1 cycle.
  - Opcode 7, 0, or 8..255: ignored; stay in IDLE.
- SKIP:
  - Each o_RX_DV decrements the count.
  - The pulse that brings the count to 0 returns to IDLE.
  - No TX activity; payload byte values are never decoded.
- SEND:
  - Each o_RX_DV means the master clocked out the current byte; the received byte value is ignored.
  - If idx < len-1: idx++, and next cycle i_TX_DV=1 with i_TX_Byte=byte[idx+1].
  - If idx = len-1: next cycle i_TX_DV=1 with i_TX_Byte=IDLE_FILL, then go to IDLE.
- i_TX_DV is always a single-cycle pulse; i_TX_Byte holds its value between pulses.
- The snapshot isolates the readback from parameter writes made during a read; bytes always come from the snapshot, never from live inputs.
- Reset mid-operation returns everything to reset values. A partial readback is abandoned with no fill pulse. The next command restarts at byte 0.
- o_RX_DV arriving in the same cycle as an i_TX_DV pulse is still honoured.
- The idx counter is 6 bits; 0..32 is sufficient and it never wraps.

Optional Feature:
- Macro READBACK_CHECKSUM_EN.
- Defined:
  - The region length grows by one byte.
  - The extra trailing byte is the XOR of all data bytes sent in that readback, accumulated from the snapshot.
  - The fill pulse follows the checksum byte.
- Undefined: no checksum byte and no accumulator logic.

Decomposition:
- Shared package chacha_spi_pkg holds:
  - opcode constants (WR_KEY=1 .. START=7)
  - region byte counts (32/12/4)
  - the readback state enum
- The writer uses the same package.
- One natural sub-module: readback_byte_sel, a combinational mux selecting a snapshot byte by region and idx.

Test Plan:
- Key readback: io_key_n = {4n+3, 4n+2, 4n+1, 4n} in bytes, then send opcode 4 followed by 32 dummy bytes. Required:
  - 33 i_TX_DV pulses carrying bytes 0x00..0x1F, then IDLE_FILL.
  - o_Busy falls after the 32nd dummy byte.
  - With READBACK_CHECKSUM_EN: 34 pulses, with checksum byte 0x00.
- Position readback: io_position=32'hDEADBEEF, then opcode 6 and 4 dummies. Required: bytes EF, BE, AD, DE, then fill. With checksum enabled: EF, BE, AD, DE, 22, then fill.
- Payload skip: opcode 1 followed by 32 payload bytes all equal to 0x04, then opcode 5. Required:
  - No i_TX_DV during the payload.
  - Opcode 5 then triggers the nonce readback (12 bytes + fill).
- Snapshot isolation: start an opcode-6 read, and after 2 bytes change io_position to 32'h0. Required: the remaining bytes are still AD, DE.
- Reset mid-read: assert i_Rst_L=0 during a key read at byte 10. Required:
  - i_TX_DV=0, i_TX_Byte=IDLE_FILL, o_Busy=0.
  - A fresh opcode 4 restarts at byte 0x00.
- Ignored opcodes: send 0x07, 0x00 and 0x09 in IDLE. Required: no i_TX_DV, o_Busy stays 0.
